// File: rtl/cdb_arbiter_if.sv
// Writeback bundle between the execution units and the CDB arbiter.
// master = FU/consumer side, slave = arbiter.
interface cdb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int PREG_WIDTH = 7,
  parameter int NUM_FU     = 3
);
  logic [NUM_FU-1:0]            i_fu_valid;
  logic [NUM_FU*DATA_WIDTH-1:0] i_fu_result;
  logic [NUM_FU*PREG_WIDTH-1:0] i_fu_prd;
  logic [NUM_FU*ROB_WIDTH-1:0]  i_fu_rob_tag;
  logic [NUM_FU-1:0]            o_fu_ready;
  logic                         o_cdb_valid;
  logic [DATA_WIDTH-1:0]        o_cdb_result;
  logic [PREG_WIDTH-1:0]        o_cdb_prd;
  logic [ROB_WIDTH-1:0]         o_cdb_rob_tag;

  modport master (
    output i_fu_valid, i_fu_result, i_fu_prd, i_fu_rob_tag,
    input  o_fu_ready, o_cdb_valid, o_cdb_result, o_cdb_prd, o_cdb_rob_tag
  );

  modport slave (
    input  i_fu_valid, i_fu_result, i_fu_prd, i_fu_rob_tag,
    output o_fu_ready, o_cdb_valid, o_cdb_result, o_cdb_prd, o_cdb_rob_tag
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Purpose: buffer per-FU writeback results and serialise them round-robin onto a registered CDB.
// Latency: 2 edges from FU valid to CDB valid (1 into the buffer, 1 through the arbiter register).
// Backpressure: per-FU ready drops while that buffer is full; the CDB itself is never stalled.

module cdb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             push_rdy,
  input  logic             pop,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             do_pop;

  // Ready looks only at the registered count: a same-cycle pop never frees a slot early.
  assign push_rdy = !reset && (count < CNT_W'(DEPTH));
  assign head_vld = (count != '0);
  assign head_dat = mem[rd_ptr];
  assign push     = push_vld && push_rdy;
  assign do_pop   = pop && head_vld;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module cdb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int PREG_WIDTH = 7,
  parameter int NUM_FU     = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flush,
  cdb_arbiter_if.slave  bus
);
  localparam int RR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [PREG_WIDTH-1:0] prd;
    logic [ROB_WIDTH-1:0]  rob_tag;
  } entry_t;

  entry_t                push_dat [NUM_FU];
  entry_t                head_dat [NUM_FU];
  entry_t                win;
  logic [NUM_FU-1:0]     req;
  logic [NUM_FU-1:0]     pop;
  logic [NUM_FU-1:0]     fu_ready;
  logic [RR_W-1:0]       rr_q;
  logic [RR_W-1:0]       grant_idx;
  logic                  any_grant;
  logic                  cdb_valid_q;
  logic [DATA_WIDTH-1:0] cdb_result_q;
  logic [PREG_WIDTH-1:0] cdb_prd_q;
  logic [ROB_WIDTH-1:0]  cdb_rob_tag_q;

  function automatic logic [RR_W-1:0] rr_add(input logic [RR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_FU) begin
      s = s - NUM_FU;
    end
    return RR_W'(s);
  endfunction

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    assign push_dat[i] = '{
      result:  bus.i_fu_result[i*DATA_WIDTH +: DATA_WIDTH],
      prd:     bus.i_fu_prd[i*PREG_WIDTH +: PREG_WIDTH],
      rob_tag: bus.i_fu_rob_tag[i*ROB_WIDTH +: ROB_WIDTH]
    };
    assign pop[i] = any_grant && (grant_idx == RR_W'(i));

    cdb_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (i_flush),
      .push_vld (bus.i_fu_valid[i]),
      .push_dat (push_dat[i]),
      .push_rdy (fu_ready[i]),
      .pop      (pop[i]),
      .head_vld (req[i]),
      .head_dat (head_dat[i])
    );
  end

  // First requester at or after rr_q, wrapping modulo NUM_FU.
  always_comb begin
    any_grant = 1'b0;
    grant_idx = rr_q;
    for (int k = 0; k < NUM_FU; k++) begin
      if (!any_grant && req[rr_add(rr_q, k)]) begin
        any_grant = 1'b1;
        grant_idx = rr_add(rr_q, k);
      end
    end
    win = head_dat[grant_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q          <= '0;
      cdb_valid_q   <= 1'b0;
      cdb_result_q  <= '0;
      cdb_prd_q     <= '0;
      cdb_rob_tag_q <= '0;
    end else if (i_flush) begin
      cdb_valid_q <= 1'b0;
    end else begin
      cdb_valid_q <= any_grant;
      if (any_grant) begin
        rr_q          <= rr_add(grant_idx, 1);
        cdb_result_q  <= win.result;
        cdb_prd_q     <= win.prd;
        cdb_rob_tag_q <= win.rob_tag;
      end
    end
  end

  assign bus.o_fu_ready    = fu_ready;
  assign bus.o_cdb_valid   = cdb_valid_q;
  assign bus.o_cdb_result  = cdb_result_q;
  assign bus.o_cdb_prd     = cdb_prd_q;
  assign bus.o_cdb_rob_tag = cdb_rob_tag_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, round-robin order, streaming, backpressure, flush, reset.
module tb_cdb_arbiter;
  localparam int DW = 32;
  localparam int RW = 4;
  localparam int PW = 7;
  localparam int NF = 3;
  localparam int FD = 2;

  logic clk = 1'b0;
  logic reset;
  logic i_flush;
  int   errors = 0;
  int   checks = 0;
  int   n0;
  int   n1;
  logic acc0;
  logic acc1;
  logic [31:0] exp4 [10];

  cdb_arbiter_if #(.DATA_WIDTH(DW), .ROB_WIDTH(RW), .PREG_WIDTH(PW), .NUM_FU(NF)) bus ();

  cdb_arbiter #(
    .DATA_WIDTH (DW),
    .ROB_WIDTH  (RW),
    .PREG_WIDTH (PW),
    .NUM_FU     (NF),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_flush (i_flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cdb(input string tag, input logic [31:0] res, input logic [6:0] prd,
                           input logic [3:0] rob);
    check({tag, "_valid"}, 64'(bus.o_cdb_valid), 64'd1);
    check({tag, "_result"}, 64'(bus.o_cdb_result), 64'(res));
    check({tag, "_prd"}, 64'(bus.o_cdb_prd), 64'(prd));
    check({tag, "_tag"}, 64'(bus.o_cdb_rob_tag), 64'(rob));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic v, input logic [31:0] res, input logic [6:0] prd,
                        input logic [3:0] rob);
    bus.i_fu_valid[i]             = v;
    bus.i_fu_result[i*DW +: DW]   = res;
    bus.i_fu_prd[i*PW +: PW]      = prd;
    bus.i_fu_rob_tag[i*RW +: RW]  = rob;
  endtask

  task automatic clear_fu();
    for (int i = 0; i < NF; i++) set_fu(i, 1'b0, 32'd0, 7'd0, 4'd0);
  endtask

  initial begin
    exp4 = '{32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h202,
             32'h103, 32'h203, 32'h104, 32'h204};
    reset   = 1'b1;
    i_flush = 1'b0;
    bus.i_fu_valid   = '0;
    bus.i_fu_result  = '0;
    bus.i_fu_prd     = '0;
    bus.i_fu_rob_tag = '0;

    // Reset state
    tick();
    tick();
    check("rst_ready", 64'(bus.o_fu_ready), 64'd0);
    check("rst_valid", 64'(bus.o_cdb_valid), 64'd0);
    check("rst_result", 64'(bus.o_cdb_result), 64'd0);
    check("rst_prd", 64'(bus.o_cdb_prd), 64'd0);
    check("rst_tag", 64'(bus.o_cdb_rob_tag), 64'd0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", 64'(bus.o_fu_ready), 64'b111);

    // Single ALU result: 2-edge latency, one-cycle broadcast
    set_fu(0, 1'b1, 32'h5, 7'd7, 4'd3);
    tick();
    clear_fu();
    check("t1_e0_valid", 64'(bus.o_cdb_valid), 64'd0);
    check("t1_e0_ready0", 64'(bus.o_fu_ready[0]), 64'd1);
    tick();
    check_cdb("t1", 32'h5, 7'd7, 4'd3);
    check("t1_e1_ready0", 64'(bus.o_fu_ready[0]), 64'd1);
    tick();
    check("t1_one_cycle", 64'(bus.o_cdb_valid), 64'd0);
    check("t1_hold_result", 64'(bus.o_cdb_result), 64'h5);

    // Simultaneous burst from all FUs, twice
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NF; i++) set_fu(i, 1'b1, 32'h11 * (i + 1), 7'(11 + i), 4'(i + 1));
    tick();
    clear_fu();
    check("t2_push_valid", 64'(bus.o_cdb_valid), 64'd0);
    tick();
    check_cdb("t2_a", 32'h11, 7'd11, 4'd1);
    tick();
    check_cdb("t2_b", 32'h22, 7'd12, 4'd2);
    tick();
    check_cdb("t2_c", 32'h33, 7'd13, 4'd3);
    tick();
    check("t2_idle", 64'(bus.o_cdb_valid), 64'd0);
    for (int i = 0; i < NF; i++) set_fu(i, 1'b1, 32'h11 * (i + 4), 7'(14 + i), 4'(i + 4));
    tick();
    clear_fu();
    tick();
    check_cdb("t2_d", 32'h44, 7'd14, 4'd4);
    tick();
    check_cdb("t2_e", 32'h55, 7'd15, 4'd5);
    tick();
    check_cdb("t2_f", 32'h66, 7'd16, 4'd6);
    tick();
    check("t2_idle2", 64'(bus.o_cdb_valid), 64'd0);

    // Continuous single-FU stream on FU1
    for (int t = 0; t < 8; t++) begin
      set_fu(1, 1'b1, 32'h300 + 32'(t), 7'd40, 4'(t));
      tick();
      check("t3_ready1", 64'(bus.o_fu_ready[1]), 64'd1);
      if (t >= 1) begin
        check("t3_valid", 64'(bus.o_cdb_valid), 64'd1);
        check("t3_tag", 64'(bus.o_cdb_rob_tag), 64'(t - 1));
      end
    end
    clear_fu();
    tick();
    check_cdb("t3_last", 32'h307, 7'd40, 4'd7);
    tick();
    check("t3_idle", 64'(bus.o_cdb_valid), 64'd0);

    // FU0 and FU1 both streaming; FUs hold data while not ready
    n0 = 0;
    n1 = 0;
    for (int e = 1; e <= 8; e++) begin
      set_fu(0, 1'b1, 32'h100 + 32'(n0), 7'd1, 4'(n0));
      set_fu(1, 1'b1, 32'h200 + 32'(n1), 7'd2, 4'(n1));
      acc0 = bus.o_fu_ready[0];
      acc1 = bus.o_fu_ready[1];
      tick();
      if (acc0) n0++;
      if (acc1) n1++;
      if (e == 1) check("t4_first_valid", 64'(bus.o_cdb_valid), 64'd0);
      if (e >= 2) begin
        check("t4_valid", 64'(bus.o_cdb_valid), 64'd1);
        check("t4_result", 64'(bus.o_cdb_result), 64'(exp4[e-2]));
      end
      if (e == 2) check("t4_ready0_one", 64'(bus.o_fu_ready[0]), 64'd1);
      if (e == 3) check("t4_ready0_full", 64'(bus.o_fu_ready[0]), 64'd0);
    end
    check("t4_accepted0", 64'(n0), 64'd5);
    check("t4_accepted1", 64'(n1), 64'd5);
    clear_fu();
    for (int e = 9; e <= 11; e++) begin
      tick();
      check("t4_drain_valid", 64'(bus.o_cdb_valid), 64'd1);
      check("t4_drain_result", 64'(bus.o_cdb_result), 64'(exp4[e-2]));
    end
    tick();
    check("t4_idle", 64'(bus.o_cdb_valid), 64'd0);

    // Flush with FU2 full and a broadcast pending
    set_fu(0, 1'b1, 32'h80, 7'd8, 4'd8);
    tick();
    clear_fu();
    tick();
    check_cdb("t5_pre", 32'h80, 7'd8, 4'd8);
    set_fu(1, 1'b1, 32'hC0, 7'd12, 4'd12);
    set_fu(2, 1'b1, 32'h90, 7'd9, 4'd9);
    tick();
    clear_fu();
    check("t5_c_valid", 64'(bus.o_cdb_valid), 64'd0);
    set_fu(2, 1'b1, 32'hA0, 7'd10, 4'd10);
    tick();
    clear_fu();
    check_cdb("t5_pending", 32'hC0, 7'd12, 4'd12);
    check("t5_ready_fu2_full", 64'(bus.o_fu_ready), 64'b011);
    i_flush = 1'b1;
    set_fu(0, 1'b1, 32'hD0, 7'd13, 4'd13);
    tick();
    i_flush = 1'b0;
    clear_fu();
    check("t5_flush_valid", 64'(bus.o_cdb_valid), 64'd0);
    check("t5_flush_ready", 64'(bus.o_fu_ready), 64'b111);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t5_no_flushed", 64'(bus.o_cdb_valid), 64'd0);
    end

    // Reset with buffers full
    for (int i = 0; i < NF; i++) set_fu(i, 1'b1, 32'hE0 + 32'(i), 7'(20 + i), 4'(i));
    tick();
    tick();
    check("t6_ready_full", 64'(bus.o_fu_ready), 64'b100);
    reset = 1'b1;
    #1;
    check("t6_ready_in_rst", 64'(bus.o_fu_ready), 64'd0);
    tick();
    check("t6_ready_rst_edge", 64'(bus.o_fu_ready), 64'd0);
    check("t6_rst_valid", 64'(bus.o_cdb_valid), 64'd0);
    check("t6_rst_result", 64'(bus.o_cdb_result), 64'd0);
    check("t6_rst_prd", 64'(bus.o_cdb_prd), 64'd0);
    check("t6_rst_tag", 64'(bus.o_cdb_rob_tag), 64'd0);
    reset = 1'b0;
    clear_fu();
    #1;
    check("t6_ready_after", 64'(bus.o_fu_ready), 64'b111);
    set_fu(1, 1'b1, 32'hABCD, 7'd33, 4'd5);
    tick();
    clear_fu();
    check("t6_e0_valid", 64'(bus.o_cdb_valid), 64'd0);
    tick();
    check_cdb("t6_first", 32'hABCD, 7'd33, 4'd5);
    tick();
    check("t6_idle", 64'(bus.o_cdb_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Collects writeback results from NUM_FU execution units (ALU, branch, LSU, ...) and serialises them onto the single Common Data Bus (CDB).
- The CDB feeds the PRF write port, RS wakeup and ROB completion.
- Each FU port has a small buffer with a valid/ready handshake, so an FU can complete while the CDB is busy.
- Buffered results are arbitrated round-robin onto a registered CDB output, and a global flush squashes everything in flight.

Parameters:
DATA_WIDTH, 32, result width
ROB_WIDTH, 4, ROB tag width
PREG_WIDTH, 7, physical register index width
NUM_FU, 3, number of FU writeback ports (index 0 = ALU)
FIFO_DEPTH, 2, entries per FU buffer (power of 2, >=2)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
i_flush  input  1  squash all buffered and outgoing results (mispredict recovery)
i_fu_valid  input  NUM_FU  per-FU result valid
i_fu_result  input  NUM_FU*DATA_WIDTH  packed results, FU i at [i*DATA_WIDTH +: DATA_WIDTH]
i_fu_prd  input  NUM_FU*PREG_WIDTH  packed destination pregs
i_fu_rob_tag  input  NUM_FU*ROB_WIDTH  packed ROB tags
o_fu_ready  output  NUM_FU  per-FU buffer can accept
o_cdb_valid  output  1  CDB broadcast valid
o_cdb_result  output  DATA_WIDTH  broadcast data
o_cdb_prd  output  PREG_WIDTH  broadcast destination preg
o_cdb_rob_tag  output  ROB_WIDTH  broadcast ROB tag

Behaviour:
Reset:
- While reset=1, at each edge: all buffers emptied (pointers and counts = 0), RR pointer = 0, and o_cdb_valid/result/prd/rob_tag = 0.
- o_fu_ready is forced 0 combinationally while reset=1.

Per-FU buffer:
- FIFO of FIFO_DEPTH entries {result, prd, rob_tag}, with wrapping rd/wr pointers and a count of width clog2(FIFO_DEPTH)+1.
- o_fu_ready[i] = !reset && count_i < FIFO_DEPTH. It is computed from the registered count only; a same-cycle pop does not raise ready. There is no pass-through.
- Push when i_fu_valid[i] && o_fu_ready[i] at the edge. A valid asserted while ready=0 is not accepted, and the FU must hold it.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance.

Arbitration (combinational on registered state, each cycle):
- Request i = count_i != 0.
- Grant the first requester searching from rr_ptr upward, modulo NUM_FU.
- On a grant g at the edge: pop FIFO g, and set rr_ptr = (g+1) mod NUM_FU.
- With no requests, rr_ptr holds.
- At most one grant per cycle.

CDB register:
- At each edge, o_cdb_valid = any_grant.
- When a grant occurs, o_cdb_result/prd/rob_tag are loaded from the winner's FIFO head; otherwise they hold their previous values.
- Each broadcast is valid for exactly one cycle. There is no CDB backpressure.
- prd = 0 entries are broadcast like any other, since the ROB needs completion.

Latency:
- Result accepted at edge E0 into an idle arbiter is granted during the next cycle and is visible on the CDB after edge E1. Minimum latency is 2 edges from valid to CDB.

Throughput:
- 1 broadcast per cycle.
- Under a continuous single-FU stream, FIFO_DEPTH=2 sustains 1 result/cycle.

Flush:
- An edge with i_flush=1 empties all FIFOs and clears o_cdb_valid to 0.
- Pushes and grants presented in that cycle are discarded.
- rr_ptr is unchanged.
- reset takes priority over i_flush.

Pointer wrap:
- rd/wr pointers wrap modulo FIFO_DEPTH.
- Entry order within an FU is strictly preserved (FIFO).

Test Plan:
- Single ALU result (FU0 valid=1, result=0x0000_0005, prd=7, tag=3) pulsed one cycle on an idle arbiter -> o_cdb_valid high exactly one cycle, 2 edges later, with 5/7/3; o_fu_ready[0] remains 1.
- All 3 FUs assert valid in the same cycle (tags 1, 2, 3) after reset -> CDB shows tags 1, 2, 3 on three consecutive cycles; the next simultaneous burst (tags 4, 5, 6) is granted starting at FU0 again, since rr_ptr wrapped to 0.
- FU1 holds valid continuously with incrementing tags 0..7 while FUs 0 and 2 are idle -> tags 0..7 appear in order, one per cycle; o_fu_ready[1] never drops.
- Backpressure: FU0 and FU1 stream continuously -> broadcasts alternate FU0/FU1; o_fu_ready[0] deasserts when its FIFO reaches 2 entries; no result is lost or duplicated, and each FU's tags stay in order.
- Flush: buffer 2 entries in FU2 plus a pending broadcast, then assert i_flush for 1 cycle -> next cycle o_cdb_valid=0, all o_fu_ready=1, and no flushed tag ever appears on the CDB.
- Reset mid-stream with FIFOs full -> o_fu_ready=0 while reset is high; after reset all outputs are 0 and the first new result is broadcast with 2-edge latency.
